qcldpc_info_feeder: RTL and testbench

// - Upstream stage of the QC-LDPC encoder. Packs a narrow valid/ready input stream into
//   Z-bit info blocks and presents them one block at a time to the encoder core.
// - Tags each block with its index, first/last flags and the latched one-hot lifting-size

---
 rtl/qcldpc_pkg.sv | 26 ++
 rtl/qcldpc_info_feeder_if.sv | 33 +++
 rtl/qcldpc_word_packer.sv | 21 ++
 rtl/qcldpc_info_feeder.sv | 101 ++++++++++
 tb/tb_qcldpc_info_feeder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/qcldpc_pkg.sv
// rtl/qcldpc_pkg.sv - shared QC-LDPC encoder constants, state type and helpers
package qcldpc_pkg;

  localparam int DEF_NUM_Z         = 3;
  localparam int DEF_MAX_Z         = 81;
  localparam int DEF_DATA_W        = 27;
  localparam int DEF_NUM_INFO_BLKS = 20;
  localparam int DEF_Z_VALUES [DEF_NUM_Z] = '{27, 54, 81};

  typedef enum logic [1:0] {IDLE, FILL, HOLD} feed_state_t;

  // Highest set bit wins; callers only rely on it for one-hot inputs.
  function automatic int onehot_to_idx(input logic [31:0] req_z);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (req_z[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int words_per_blk(input int idx);
    return DEF_Z_VALUES[idx] / DEF_DATA_W;
  endfunction

endpackage

// File: rtl/qcldpc_info_feeder_if.sv
// rtl/qcldpc_info_feeder_if.sv - word stream in, tagged info block out
interface qcldpc_info_feeder_if
  #(parameter int NUM_Z         = qcldpc_pkg::DEF_NUM_Z,
    parameter int MAX_Z         = qcldpc_pkg::DEF_MAX_Z,
    parameter int DATA_W        = qcldpc_pkg::DEF_DATA_W,
    parameter int NUM_INFO_BLKS = qcldpc_pkg::DEF_NUM_INFO_BLKS);

  localparam int IDX_W = $clog2(NUM_INFO_BLKS);

  logic [NUM_Z-1:0]  req_z;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              blk_valid;
  logic              blk_ready;
  logic [MAX_Z-1:0]  info_blk;
  logic [IDX_W-1:0]  blk_idx;
  logic              blk_first;
  logic              blk_last;
  logic [NUM_Z-1:0]  z_sel;
  logic              cfg_err;

  modport slave (
    input  req_z, s_valid, s_data, blk_ready,
    output s_ready, blk_valid, info_blk, blk_idx, blk_first, blk_last, z_sel, cfg_err
  );

  modport master (
    output req_z, s_valid, s_data, blk_ready,
    input  s_ready, blk_valid, info_blk, blk_idx, blk_first, blk_last, z_sel, cfg_err
  );

endinterface

// File: rtl/qcldpc_word_packer.sv
// rtl/qcldpc_word_packer.sv - indexed word write into the block assembly register
module qcldpc_word_packer
  #(parameter int MAX_Z  = 81,
    parameter int DATA_W = 27,
    parameter int CNT_W  = 2)
  (input  logic              CLK,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [CNT_W-1:0]  word_cnt,
   input  logic [DATA_W-1:0] s_data,
   output logic [MAX_Z-1:0]  blk_reg);

  always_ff @(posedge CLK) begin
    if (clear) begin
      blk_reg <= '0;
    end else if (wr_en) begin
      blk_reg[int'(word_cnt)*DATA_W +: DATA_W] <= s_data;
    end
  end

endmodule

// File: rtl/qcldpc_info_feeder.sv
// rtl/qcldpc_info_feeder.sv - packs input words into Z-bit info blocks for the encoder core
module qcldpc_info_feeder
  import qcldpc_pkg::*;
  #(parameter int NUM_Z         = qcldpc_pkg::DEF_NUM_Z,
    parameter int MAX_Z         = qcldpc_pkg::DEF_MAX_Z,
    parameter int NUM_INFO_BLKS = qcldpc_pkg::DEF_NUM_INFO_BLKS,
    parameter int DATA_W        = qcldpc_pkg::DEF_DATA_W,
    parameter int Z_VALUES [NUM_Z] = qcldpc_pkg::DEF_Z_VALUES)
  (input logic CLK,
   input logic rst,
   qcldpc_info_feeder_if.slave bus);

  localparam int IDX_W = $clog2(NUM_INFO_BLKS);
  localparam int CNT_W = $clog2(MAX_Z / DATA_W + 1);

  for (genvar gi = 0; gi < NUM_Z; gi++) begin : g_zchk
    if (Z_VALUES[gi] % DATA_W != 0) begin : g_bad
      $fatal(1, "Z_VALUES entry is not a multiple of DATA_W");
    end
  end

  feed_state_t       state, state_n;
  logic [CNT_W-1:0]  word_cnt, wpb, req_wpb;
  logic [IDX_W-1:0]  blk_idx;
  logic [NUM_Z-1:0]  z_sel;
  logic              cfg_err, blk_first, blk_last;
  logic              req_ok, s_ready, word_acc, blk_acc, last_blk;
  logic [MAX_Z-1:0]  blk_reg;

  assign req_ok   = $onehot(bus.req_z);
  assign req_wpb  = CNT_W'(Z_VALUES[onehot_to_idx(32'(bus.req_z))] / DATA_W);
  assign s_ready  = !rst && ((state == IDLE) ? req_ok : (state == FILL));
  assign word_acc = bus.s_valid && s_ready;
  assign blk_acc  = (state == HOLD) && bus.blk_ready;
  assign last_blk = (blk_idx == IDX_W'(NUM_INFO_BLKS - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (word_acc) state_n = (req_wpb == CNT_W'(1)) ? HOLD : FILL;
      FILL:    if (word_acc && (word_cnt == wpb - 1'b1)) state_n = HOLD;
      HOLD:    if (blk_acc) state_n = last_blk ? IDLE : FILL;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      word_cnt  <= '0;
      wpb       <= '0;
      blk_idx   <= '0;
      z_sel     <= '0;
      cfg_err   <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && bus.s_valid && !req_ok;
      if (word_acc) word_cnt <= word_cnt + 1'b1;
      // z_sel and block size are frozen for the rest of the codeword
      if ((state == IDLE) && word_acc) begin
        z_sel <= bus.req_z;
        wpb   <= req_wpb;
      end
      if ((state_n == HOLD) && (state != HOLD)) begin
        blk_first <= (blk_idx == '0);
        blk_last  <= last_blk;
      end
      if (blk_acc) begin
        word_cnt  <= '0;
        blk_first <= 1'b0;
        blk_last  <= 1'b0;
        blk_idx   <= last_blk ? '0 : blk_idx + 1'b1;
      end
    end
  end

  // Clearing on block accept keeps pad bits zero for the next fill or codeword.
  qcldpc_word_packer #(.MAX_Z(MAX_Z), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_packer (
    .CLK      (CLK),
    .clear    (rst || blk_acc),
    .wr_en    (word_acc),
    .word_cnt (word_cnt),
    .s_data   (bus.s_data),
    .blk_reg  (blk_reg)
  );

  assign bus.s_ready   = s_ready;
  assign bus.blk_valid = (state == HOLD);
  assign bus.info_blk  = blk_reg;
  assign bus.blk_idx   = blk_idx;
  assign bus.blk_first = blk_first;
  assign bus.blk_last  = blk_last;
  assign bus.z_sel     = z_sel;
  assign bus.cfg_err   = cfg_err;

endmodule

// File: tb/tb_qcldpc_info_feeder.sv
// tb/tb_qcldpc_info_feeder.sv - directed and randomized scoreboard bench for qcldpc_info_feeder
module tb_qcldpc_info_feeder;

  typedef struct {
    logic [26:0] data;
    logic [2:0]  z;
  } word_t;

  typedef struct {
    logic [80:0] blk;
    int          idx;
    logic        first;
    logic        last;
    logic [2:0]  z;
  } blk_t;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  word_t word_q[$];
  blk_t  exp_q[$];

  qcldpc_info_feeder_if bus ();

  qcldpc_info_feeder dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},   96'(bus.s_ready),   96'(0));
    check({tag, "_blk_valid"}, 96'(bus.blk_valid), 96'(0));
    check({tag, "_info_blk"},  96'(bus.info_blk),  96'(0));
    check({tag, "_blk_idx"},   96'(bus.blk_idx),   96'(0));
    check({tag, "_blk_first"}, 96'(bus.blk_first), 96'(0));
    check({tag, "_blk_last"},  96'(bus.blk_last),  96'(0));
    check({tag, "_z_sel"},     96'(bus.z_sel),     96'(0));
    check({tag, "_cfg_err"},   96'(bus.cfg_err),   96'(0));
  endtask

  // Reference: block b of a codeword is words b*WPB..b*WPB+WPB-1, word 0 in the LSBs.
  task automatic add_blocks(input logic [2:0] zmodel, input logic [2:0] zlater,
                            input int b0, input int b1, input bit seq, inout logic [26:0] seqw);
    int    zval;
    int    wpb;
    bit    first_word;
    blk_t  e;
    logic [26:0] w;
    zval = (zmodel == 3'b001) ? 27 : (zmodel == 3'b010) ? 54 : 81;
    wpb = zval / 27;
    first_word = 1'b1;
    for (int b = b0; b < b1; b++) begin
      e.blk = '0;
      for (int k = 0; k < wpb; k++) begin
        if (seq) begin
          w = seqw;
          seqw = seqw + 27'd1;
        end else begin
          w = 27'($urandom);
        end
        word_q.push_back('{w, first_word ? zmodel : zlater});
        first_word = 1'b0;
        e.blk = e.blk | (81'(w) << (27 * k));
      end
      e.idx = b;
      e.first = (b == 0);
      e.last = (b == 19);
      e.z = zmodel;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_engine(input int v_pct, input int r_pct);
    int   cyc;
    blk_t e;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
      if (word_q.size() > 0) begin
        bus.req_z = word_q[0].z;
        bus.s_data = word_q[0].data;
        bus.s_valid = ($urandom_range(99) < v_pct);
      end else begin
        bus.s_valid = 1'b0;
      end
      bus.blk_ready = ($urandom_range(99) < r_pct);
      #1;
      if (bus.s_valid && bus.s_ready) word_q.delete(0);
      if (bus.blk_valid && bus.blk_ready) begin
        check("sb_blk_expected", 96'(exp_q.size() > 0), 96'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_info_blk", 96'(bus.info_blk),  96'(e.blk));
          check("sb_blk_idx",  96'(bus.blk_idx),   96'(e.idx));
          check("sb_first",    96'(bus.blk_first), 96'(e.first));
          check("sb_last",     96'(bus.blk_last),  96'(e.last));
          check("sb_z_sel",    96'(bus.z_sel),     96'(e.z));
        end
      end
    end
    @(negedge CLK);
    bus.s_valid = 1'b0;
    bus.blk_ready = 1'b0;
    check("engine_blocks_left", 96'(exp_q.size()), 96'(0));
    check("engine_words_left",  96'(word_q.size()), 96'(0));
  endtask

  initial begin
    logic [26:0] seqw;
    logic [26:0] wa, wb, wc, wx;
    logic [80:0] held;
    logic [2:0]  zr;

    bus.req_z = 3'b001;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.blk_ready = 1'b0;
    seqw = 27'd1;

    // Reset state, including s_ready masked while rst is high
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Z=27 codeword of words 1..20 at full rate
    add_blocks(3'b001, 3'b001, 0, 20, 1'b1, seqw);
    run_engine(100, 100);
    check("z27_idle_blk_valid", 96'(bus.blk_valid), 96'(0));
    check("z27_idle_z_sel",     96'(bus.z_sel),     96'(3'b001));
    check("z27_idle_blk_idx",   96'(bus.blk_idx),   96'(0));
    check("z27_idle_s_ready",   96'(bus.s_ready),   96'(1));

    // Z=81: three words then a stalled block
    wa = 27'h0ABCDEF;
    wb = 27'h1357913;
    wc = 27'h7654321;
    bus.req_z = 3'b100;
    bus.s_valid = 1'b1;
    bus.s_data = wa;
    @(negedge CLK);
    bus.s_data = wb;
    @(negedge CLK);
    check("z81_no_early_valid", 96'(bus.blk_valid), 96'(0));
    bus.s_data = wc;
    @(negedge CLK);
    bus.s_valid = 1'b0;
    held = {wc, wb, wa};
    check("z81_valid_after_c", 96'(bus.blk_valid), 96'(1));
    for (int i = 0; i < 5; i++) begin
      check("z81_hold_info",  96'(bus.info_blk),  96'(held));
      check("z81_hold_idx",   96'(bus.blk_idx),   96'(0));
      check("z81_hold_first", 96'(bus.blk_first), 96'(1));
      check("z81_hold_last",  96'(bus.blk_last),  96'(0));
      check("z81_hold_z_sel", 96'(bus.z_sel),     96'(3'b100));
      check("z81_hold_valid", 96'(bus.blk_valid), 96'(1));
      #1;
      check("z81_hold_s_ready", 96'(bus.s_ready), 96'(0));
      @(negedge CLK);
    end
    bus.blk_ready = 1'b1;
    @(negedge CLK);
    bus.blk_ready = 1'b0;
    check("z81_accept_valid",   96'(bus.blk_valid), 96'(0));
    check("z81_accept_s_ready", 96'(bus.s_ready),   96'(1));
    check("z81_accept_idx",     96'(bus.blk_idx),   96'(1));
    add_blocks(3'b100, 3'b100, 1, 20, 1'b0, seqw);
    run_engine(100, 100);

    // req_z switched mid-codeword is ignored; next codeword samples the new value
    add_blocks(3'b010, 3'b100, 0, 20, 1'b0, seqw);
    add_blocks(3'b100, 3'b100, 0, 20, 1'b0, seqw);
    run_engine(90, 80);

    // Non-one-hot req_z raises cfg_err and consumes nothing
    wx = 27'h5A5A5A5;
    bus.req_z = 3'b011;
    bus.s_valid = 1'b1;
    bus.s_data = wx;
    #1;
    check("cfg_s_ready_low", 96'(bus.s_ready), 96'(0));
    @(negedge CLK);
    check("cfg_err_set",     96'(bus.cfg_err),   96'(1));
    check("cfg_no_blk",      96'(bus.blk_valid), 96'(0));
    @(negedge CLK);
    check("cfg_err_level",   96'(bus.cfg_err),   96'(1));
    check("cfg_still_no_blk", 96'(bus.blk_valid), 96'(0));
    bus.req_z = 3'b001;
    #1;
    check("cfg_s_ready_back", 96'(bus.s_ready), 96'(1));
    @(negedge CLK);
    bus.s_valid = 1'b0;
    check("cfg_err_clear",  96'(bus.cfg_err),   96'(0));
    check("cfg_word_taken", 96'(bus.blk_valid), 96'(1));
    check("cfg_info_blk",   96'(bus.info_blk),  96'(wx));
    check("cfg_z_sel",      96'(bus.z_sel),     96'(3'b001));
    bus.blk_ready = 1'b1;
    @(negedge CLK);
    bus.blk_ready = 1'b0;
    check("cfg_next_idx", 96'(bus.blk_idx), 96'(1));
    add_blocks(3'b001, 3'b001, 1, 20, 1'b0, seqw);
    run_engine(100, 100);

    // Z=54: reset while block 7 is complete and held
    add_blocks(3'b010, 3'b010, 0, 7, 1'b0, seqw);
    run_engine(100, 100);
    bus.req_z = 3'b010;
    bus.s_valid = 1'b1;
    bus.s_data = 27'h7FFFFFF;
    @(negedge CLK);
    bus.s_data = 27'h6DB6DB6;
    @(negedge CLK);
    bus.s_valid = 1'b0;
    check("mid_hold_valid", 96'(bus.blk_valid), 96'(1));
    check("mid_hold_idx",   96'(bus.blk_idx),   96'(7));
    rst = 1'b1;
    @(negedge CLK);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    add_blocks(3'b001, 3'b001, 0, 20, 1'b0, seqw);
    run_engine(100, 100);

    // Throttled back-to-back codewords of random Z
    for (int c = 0; c < 3; c++) begin
      zr = 3'b001 << $urandom_range(2);
      add_blocks(zr, zr, 0, 20, 1'b0, seqw);
    end
    run_engine(60, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
